reg_wb_arbiter: RTL

Write-back arbiter for the 32x32 MIPS register file's single write port. Two write-back requesters share that port: A (ALU results) and B (load data from memory). Each requester has a valid/ready handshake and a one-entry holding slot. The block grants one slot per cycle, using round-robin with same-register ordering protection. It also drives a read-hazard stall for the decode stage, covering writes that are held or in flight.

---
 rtl/reg_wb_pkg.sv | 15 +
 rtl/wb_slot.sv | 58 +++++
 rtl/reg_wb_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/reg_wb_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Pointer encoding identifies which requester was granted last.
package reg_wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/wb_slot.sv
// One-entry write-back holding slot with valid/ready handshake.
// Writes to the zero register complete the handshake but are dropped.
module wb_slot
    import reg_wb_pkg::*;
#(
    parameter int DATA_W = reg_wb_pkg::DATA_W,
    parameter int ADDR_W = reg_wb_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] reg_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              grant_i,
    output logic              load_o,
    output logic              occ_o,
    output logic [ADDR_W-1:0] reg_o,
    output logic [DATA_W-1:0] data_o
);

    logic              occ_q, occ_d;
    logic [ADDR_W-1:0] reg_q, reg_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign ready_o = rst_ni & (~occ_q | grant_i);
    assign load_o  = valid_i & ready_o & (reg_i != ADDR_W'(ZERO_REG));

    always_comb begin
        occ_d  = occ_q;
        reg_d  = reg_q;
        data_d = data_q;
        if (load_o) begin
            occ_d  = 1'b1;
            reg_d  = reg_i;
            data_d = data_i;
        end else if (grant_i) begin
            occ_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q  <= 1'b0;
            reg_q  <= '0;
            data_q <= '0;
        end else begin
            occ_q  <= occ_d;
            reg_q  <= reg_d;
            data_q <= data_d;
        end
    end

    assign occ_o  = occ_q;
    assign reg_o  = reg_q;
    assign data_o = data_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Two-requester write-back arbiter for the register file write port,
// with same-register ordering, round-robin fairness and read-hazard stall.
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int DATA_W = reg_wb_pkg::DATA_W,
    parameter int ADDR_W = reg_wb_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              A_valid,
    output logic              A_ready,
    input  logic [ADDR_W-1:0] A_reg,
    input  logic [DATA_W-1:0] A_data,
    input  logic              B_valid,
    output logic              B_ready,
    input  logic [ADDR_W-1:0] B_reg,
    input  logic [DATA_W-1:0] B_data,
    output logic              Reg_write,
    output logic [ADDR_W-1:0] Write_reg,
    output logic [DATA_W-1:0] Write_data,
    input  logic [ADDR_W-1:0] Read_reg1,
    input  logic [ADDR_W-1:0] Read_reg2,
    output logic              Stall,
    output logic [15:0]       Conflict_cnt
);

    logic              a_occ, b_occ, a_load, b_load;
    logic              grant_a, grant_b, same_reg;
    logic [ADDR_W-1:0] a_reg, b_reg;
    logic [DATA_W-1:0] a_data, b_data;

    logic              a_older_q, a_older_d;
    logic              last_q, last_d;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              hit1, hit2;

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .valid_i (A_valid),
        .ready_o (A_ready),
        .reg_i   (A_reg),
        .data_i  (A_data),
        .grant_i (grant_a),
        .load_o  (a_load),
        .occ_o   (a_occ),
        .reg_o   (a_reg),
        .data_o  (a_data)
    );

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_b (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .valid_i (B_valid),
        .ready_o (B_ready),
        .reg_i   (B_reg),
        .data_i  (B_data),
        .grant_i (grant_b),
        .load_o  (b_load),
        .occ_o   (b_occ),
        .reg_o   (b_reg),
        .data_o  (b_data)
    );

    // Same destination must drain oldest-first; otherwise alternate.
    assign same_reg = (a_reg == b_reg);
    assign grant_a  = a_occ & (~b_occ |
                      (same_reg ? a_older_q : (last_q == REQ_B)));
    assign grant_b  = b_occ & ~grant_a;

    always_comb begin
        a_older_d    = a_older_q;
        last_d       = last_q;
        reg_write_d  = grant_a | grant_b;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        cnt_d        = cnt_q;
        if (a_load && b_load) begin
            a_older_d = 1'b1;
        end else if (a_load) begin
            a_older_d = 1'b0;
        end else if (b_load) begin
            a_older_d = 1'b1;
        end
        if (grant_a) begin
            last_d       = REQ_A;
            write_reg_d  = a_reg;
            write_data_d = a_data;
        end else if (grant_b) begin
            last_d       = REQ_B;
            write_reg_d  = b_reg;
            write_data_d = b_data;
        end
        if (a_occ && b_occ && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a_older_q    <= 1'b1;
            last_q       <= REQ_B;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            cnt_q        <= '0;
        end else begin
            a_older_q    <= a_older_d;
            last_q       <= last_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            cnt_q        <= cnt_d;
        end
    end

    // The register file commits late, so the write being issued still hazards.
    assign hit1 = (Read_reg1 != ADDR_W'(ZERO_REG)) &
                  ((a_occ & (a_reg == Read_reg1)) |
                   (b_occ & (b_reg == Read_reg1)) |
                   (reg_write_q & (write_reg_q == Read_reg1)));
    assign hit2 = (Read_reg2 != ADDR_W'(ZERO_REG)) &
                  ((a_occ & (a_reg == Read_reg2)) |
                   (b_occ & (b_reg == Read_reg2)) |
                   (reg_write_q & (write_reg_q == Read_reg2)));

    assign Stall        = hit1 | hit2;
    assign Reg_write    = reg_write_q;
    assign Write_reg    = write_reg_q;
    assign Write_data   = write_data_q;
    assign Conflict_cnt = cnt_q;

endmodule
